// File: rtl/chaos_pkg.sv
// Shared Q8.24 constants, FSM state encoding and the 36-to-32 bit saturator
// for the hyperchaotic Lorenz step engine.
package chaos_pkg;

  localparam int WIDTH     = 32;
  localparam int FRAC_BITS = 24;
  localparam int DWIDTH    = 36;

  localparam logic [WIDTH-1:0] INIT_VAL = 32'h0100_0000;

  typedef enum logic [2:0] {
    IDLE,
    MUL_XZ,
    MUL_XY,
    MUL_YZ,
    UPDATE,
    DONE
  } state_t;

  // In range only when the five top bits agree; otherwise clamp by sign.
  function automatic logic [WIDTH-1:0] sat32(input logic signed [DWIDTH-1:0] v);
    if ((&v[DWIDTH-1:WIDTH-1]) || !(|v[DWIDTH-1:WIDTH-1]))
      return v[WIDTH-1:0];
    return v[DWIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

endpackage

// File: rtl/chaos_step_engine_if.sv
// PIO-side bundle of the chaos step engine: software drives reset/step/shift,
// the engine returns the state vector, step counter and acknowledge.
interface chaos_step_engine_if import chaos_pkg::*; #(
  parameter int CNT_WIDTH = 13
) ();

  logic                 chaos_reset;
  logic                 chaos_step;
  logic [31:0]          chaos_shift;
  logic                 chaos_done;
  logic [CNT_WIDTH-1:0] chaos_temp;
  logic [WIDTH-1:0]     chaos_w;
  logic [WIDTH-1:0]     chaos_x;
  logic [WIDTH-1:0]     chaos_y;
  logic [WIDTH-1:0]     chaos_z;

  modport master (
    output chaos_reset, chaos_step, chaos_shift,
    input  chaos_done, chaos_temp, chaos_w, chaos_x, chaos_y, chaos_z
  );

  modport slave (
    input  chaos_reset, chaos_step, chaos_shift,
    output chaos_done, chaos_temp, chaos_w, chaos_x, chaos_y, chaos_z
  );

endinterface

// File: rtl/chaos_fxp_mul.sv
// Combinational signed Q8.24 multiply, truncating the 64-bit product to [55:24].
module chaos_fxp_mul import chaos_pkg::*; (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_p
);

  logic signed [2*WIDTH-1:0] w_full;
  logic                      w_unused;

  assign w_full   = i_a * i_b;
  assign o_p      = w_full[FRAC_BITS+WIDTH-1:FRAC_BITS];
  assign w_unused = ^{w_full[2*WIDTH-1:FRAC_BITS+WIDTH], w_full[FRAC_BITS-1:0]};

endmodule

// File: rtl/chaos_step_engine.sv
// Forward-Euler hyperchaotic Lorenz integrator; one shared multiplier is
// sequenced over xz, xy and yz before a single atomic state update.
module chaos_step_engine import chaos_pkg::*; #(
  parameter int CNT_WIDTH = 13,
  parameter int MIN_SHIFT = 4
) (
  input  logic                clk,
  input  logic                reset,
  chaos_step_engine_if.slave  bus
);

  state_t r_state, w_next;

  logic                 r_step_q, r_done;
  logic [CNT_WIDTH-1:0] r_temp;
  logic signed [WIDTH-1:0] r_w, r_x, r_y, r_z;
  logic signed [WIDTH-1:0] r_pxz, r_pxy, r_pyz;
  logic signed [WIDTH-1:0] w_mul_a, w_mul_b, w_mul_p;
  logic w_start, w_unused_shift;
  logic [4:0] w_k;

  logic signed [DWIDTH-1:0] w_we, w_xe, w_ye, w_ze, w_pxze, w_pxye, w_pyze, w_yx;
  logic signed [DWIDTH-1:0] w_dw, w_dx, w_dy, w_dz;
  logic [WIDTH-1:0] w_wn, w_xn, w_yn, w_zn;

  assign w_start        = bus.chaos_step && !r_step_q;
  assign w_unused_shift = ^bus.chaos_shift[31:5];

  chaos_fxp_mul u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_mul_p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_mul_a = r_x;
    w_mul_b = r_z;
    unique case (r_state)
      IDLE:    if (w_start) w_next = MUL_XZ;
      MUL_XZ:  w_next = MUL_XY;
      MUL_XY:  begin w_next = MUL_YZ; w_mul_b = r_y; end
      MUL_YZ:  begin w_next = UPDATE; w_mul_a = r_y; end
      UPDATE:  w_next = DONE;
      DONE:    if (!bus.chaos_step) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (bus.chaos_reset) w_next = IDLE;
  end

  // Derivatives at 36 bits; constant multiplies are shift-add only (b = 2.65625).
  always_comb begin
    w_we   = {{(DWIDTH-WIDTH){r_w[WIDTH-1]}}, r_w};
    w_xe   = {{(DWIDTH-WIDTH){r_x[WIDTH-1]}}, r_x};
    w_ye   = {{(DWIDTH-WIDTH){r_y[WIDTH-1]}}, r_y};
    w_ze   = {{(DWIDTH-WIDTH){r_z[WIDTH-1]}}, r_z};
    w_pxze = {{(DWIDTH-WIDTH){r_pxz[WIDTH-1]}}, r_pxz};
    w_pxye = {{(DWIDTH-WIDTH){r_pxy[WIDTH-1]}}, r_pxy};
    w_pyze = {{(DWIDTH-WIDTH){r_pyz[WIDTH-1]}}, r_pyz};
    w_yx   = w_ye - w_xe;
    w_dx   = (w_yx <<< 3) + (w_yx <<< 1) + w_we;
    w_dy   = (w_xe <<< 5) - (w_xe <<< 2) - w_ye - w_pxze;
    w_dz   = w_pxye - ((w_ze <<< 1) + (w_ze >>> 1) + (w_ze >>> 3) + (w_ze >>> 5));
    w_dw   = -w_pyze - w_we;
    w_k    = (bus.chaos_shift[4:0] < 5'(MIN_SHIFT)) ? 5'(MIN_SHIFT) : bus.chaos_shift[4:0];
    w_wn   = sat32(w_we + (w_dw >>> w_k));
    w_xn   = sat32(w_xe + (w_dx >>> w_k));
    w_yn   = sat32(w_ye + (w_dy >>> w_k));
    w_zn   = sat32(w_ze + (w_dz >>> w_k));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step_q <= 1'b0;
      r_done   <= 1'b0;
      r_temp   <= '0;
      r_w      <= INIT_VAL;
      r_x      <= INIT_VAL;
      r_y      <= INIT_VAL;
      r_z      <= INIT_VAL;
      r_pxz    <= '0;
      r_pxy    <= '0;
      r_pyz    <= '0;
    end else begin
      r_step_q <= bus.chaos_step;
      if (bus.chaos_reset) begin
        r_done <= 1'b0;
        r_temp <= '0;
        r_w    <= INIT_VAL;
        r_x    <= INIT_VAL;
        r_y    <= INIT_VAL;
        r_z    <= INIT_VAL;
        r_pxz  <= '0;
        r_pxy  <= '0;
        r_pyz  <= '0;
      end else begin
        unique case (r_state)
          MUL_XZ: r_pxz <= w_mul_p;
          MUL_XY: r_pxy <= w_mul_p;
          MUL_YZ: r_pyz <= w_mul_p;
          UPDATE: begin
            r_w    <= w_wn;
            r_x    <= w_xn;
            r_y    <= w_yn;
            r_z    <= w_zn;
            r_temp <= r_temp + CNT_WIDTH'(1);
            r_done <= 1'b1;
          end
          DONE:    if (!bus.chaos_step) r_done <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign bus.chaos_done = r_done;
  assign bus.chaos_temp = r_temp;
  assign bus.chaos_w    = r_w;
  assign bus.chaos_x    = r_x;
  assign bus.chaos_y    = r_y;
  assign bus.chaos_z    = r_z;

endmodule

// File: tb/tb_chaos_step_engine.sv
// Directed bench for chaos_step_engine: table of single-step vectors from the
// initial state plus hand-written handshake, soft-reset and wrap sequences.
module tb_chaos_step_engine;
  import chaos_pkg::*;

  typedef struct {
    logic [31:0] shift;
    logic [31:0] w, x, y, z;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   stepOk;
  vec_t vecs[7];

  always #5 clk = ~clk;

  chaos_step_engine_if bus ();

  chaos_step_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic checkState(input string name, input logic [31:0] w, x, y, z,
                            input logic done, input logic [12:0] temp);
    checkOutput({name, "_w"}, bus.chaos_w, w);
    checkOutput({name, "_x"}, bus.chaos_x, x);
    checkOutput({name, "_y"}, bus.chaos_y, y);
    checkOutput({name, "_z"}, bus.chaos_z, z);
    checkOutput({name, "_done"}, {31'd0, bus.chaos_done}, {31'd0, done});
    checkOutput({name, "_temp"}, {19'd0, bus.chaos_temp}, {19'd0, temp});
  endtask

  task automatic applyStimulus(input logic softRst, input logic step, input logic [31:0] shift);
    bus.chaos_reset = softRst;
    bus.chaos_step  = step;
    bus.chaos_shift = shift;
  endtask

  task automatic softReset();
    bus.chaos_reset = 1'b1;
    tick(1);
    bus.chaos_reset = 1'b0;
  endtask

  // Full four-phase handshake with bounded waits on done rising and falling.
  task automatic runStep(output bit ok);
    int n;
    ok = 1'b1;
    bus.chaos_step = 1'b1;
    n = 0;
    while (!bus.chaos_done && n < 20) begin tick(1); n++; end
    if (!bus.chaos_done) begin
      checks++; errors++; ok = 1'b0;
      $display("[TB] FAIL step_timeout actual=%0d cycles without done required=done", n);
    end
    bus.chaos_step = 1'b0;
    n = 0;
    while (bus.chaos_done && n < 5) begin tick(1); n++; end
    if (bus.chaos_done) begin
      checks++; errors++; ok = 1'b0;
      $display("[TB] FAIL release_timeout actual=done still high required=done low");
    end
  endtask

  initial begin
    vecs[0] = '{32'd8,          32'h00FE_0000, 32'h0101_0000, 32'h011A_0000, 32'h00FE_5800};
    vecs[1] = '{32'd4,          32'h00E0_0000, 32'h0110_0000, 32'h02A0_0000, 32'h00E5_8000};
    vecs[2] = '{32'd0,          32'h00E0_0000, 32'h0110_0000, 32'h02A0_0000, 32'h00E5_8000};
    vecs[3] = '{32'd3,          32'h00E0_0000, 32'h0110_0000, 32'h02A0_0000, 32'h00E5_8000};
    vecs[4] = '{32'd16,         32'h00FF_FE00, 32'h0100_0100, 32'h0100_1A00, 32'h00FF_FE58};
    vecs[5] = '{32'hFFFF_FFE8,  32'h00FE_0000, 32'h0101_0000, 32'h011A_0000, 32'h00FE_5800};
    vecs[6] = '{32'h0000_0025,  32'h00F0_0000, 32'h0108_0000, 32'h01D0_0000, 32'h00F2_C000};

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd8);
    tick(2);
    checkState("in_reset", INIT_VAL, INIT_VAL, INIT_VAL, INIT_VAL, 1'b0, 13'd0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      checkState("after_reset", INIT_VAL, INIT_VAL, INIT_VAL, INIT_VAL, 1'b0, 13'd0);
    end

    for (int i = 0; i < 7; i++) begin
      softReset();
      applyStimulus(1'b0, 1'b1, vecs[i].shift);
      tick(4);
      checkOutput($sformatf("v%0d_held_done", i), {31'd0, bus.chaos_done}, 32'd0);
      checkOutput($sformatf("v%0d_held_x", i), bus.chaos_x, INIT_VAL);
      tick(1);
      checkState($sformatf("v%0d", i), vecs[i].w, vecs[i].x, vecs[i].y, vecs[i].z, 1'b1, 13'd1);
      bus.chaos_step = 1'b0;
      tick(1);
      checkOutput($sformatf("v%0d_release", i), {31'd0, bus.chaos_done}, 32'd0);
      tick(1);
    end

    // Step held high: exactly one update, then a fresh edge gives the second.
    softReset();
    applyStimulus(1'b0, 1'b1, 32'd8);
    tick(5);
    checkState("hold_first", vecs[0].w, vecs[0].x, vecs[0].y, vecs[0].z, 1'b1, 13'd1);
    for (int c = 0; c < 20; c++) begin
      tick(1);
      checkOutput("hold_temp", {19'd0, bus.chaos_temp}, 32'd1);
      checkOutput("hold_x", bus.chaos_x, vecs[0].x);
    end
    bus.chaos_step = 1'b0;
    tick(1);
    checkOutput("hold_release_done", {31'd0, bus.chaos_done}, 32'd0);
    bus.chaos_step = 1'b1;
    tick(4);
    checkOutput("second_early_done", {31'd0, bus.chaos_done}, 32'd0);
    tick(1);
    checkOutput("second_done", {31'd0, bus.chaos_done}, 32'd1);
    checkOutput("second_temp", {19'd0, bus.chaos_temp}, 32'd2);

    // Soft reset during MUL_XY with step still high.
    bus.chaos_step = 1'b0;
    tick(1);
    bus.chaos_step = 1'b1;
    tick(2);
    bus.chaos_reset = 1'b1;
    tick(1);
    bus.chaos_reset = 1'b0;
    checkState("midreset", INIT_VAL, INIT_VAL, INIT_VAL, INIT_VAL, 1'b0, 13'd0);
    tick(10);
    checkState("midreset_hold", INIT_VAL, INIT_VAL, INIT_VAL, INIT_VAL, 1'b0, 13'd0);
    bus.chaos_step = 1'b0;
    tick(1);
    bus.chaos_step = 1'b1;
    tick(5);
    checkState("midreset_restep", vecs[0].w, vecs[0].x, vecs[0].y, vecs[0].z, 1'b1, 13'd1);

    // Counter wrap with the smallest dt.
    bus.chaos_step = 1'b0;
    tick(1);
    softReset();
    bus.chaos_shift = 32'd31;
    tick(1);
    for (int s = 0; s < 8191; s++) begin
      runStep(stepOk);
      if (!stepOk) break;
    end
    checkOutput("temp_8191", {19'd0, bus.chaos_temp}, 32'd8191);
    runStep(stepOk);
    checkOutput("temp_wrap", {19'd0, bus.chaos_temp}, 32'd0);
    checkOutput("wrap_w_unsat", {31'd0, (bus.chaos_w == 32'h7FFF_FFFF) || (bus.chaos_w == 32'h8000_0000)}, 32'd0);
    checkOutput("wrap_x_unsat", {31'd0, (bus.chaos_x == 32'h7FFF_FFFF) || (bus.chaos_x == 32'h8000_0000)}, 32'd0);
    checkOutput("wrap_y_unsat", {31'd0, (bus.chaos_y == 32'h7FFF_FFFF) || (bus.chaos_y == 32'h8000_0000)}, 32'd0);
    checkOutput("wrap_z_unsat", {31'd0, (bus.chaos_z == 32'h7FFF_FFFF) || (bus.chaos_z == 32'h8000_0000)}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chaos_step_engine.md
Name: chaos_step_engine

Overview:
- Fixed-point hyperchaotic Lorenz integrator that drives the chaos PIO bank of the HPS system.
- Consumes the PIO outputs `reset`, `step` and `shift`; produces the PIO inputs `w`, `x`, `y`, `z`, `done` and `temp`.
- Each software-requested step performs one forward-Euler update of the 4-D state in signed Q8.24.
- One shared multiplier is sequenced across the three cross products.

Parameters:
- WIDTH, 32, state/derivative word width (signed).
- FRAC_BITS, 24, fractional bits (Q8.24).
- CNT_WIDTH, 13, step counter width.
- MIN_SHIFT, 4, smallest allowed dt exponent.
- INIT_VAL, 32'h0100_0000, initial value (1.0) loaded into w, x, y and z.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- chaos_reset  in  1  synchronous soft reset from PIO
- chaos_step  in  1  step request level from PIO (4-phase handshake)
- chaos_shift  in  32  bits [4:0] = dt exponent k (dt = 2^-k); bits [31:5] ignored
- chaos_done  out  1  step complete, handshake acknowledge
- chaos_temp  out  13  completed-step counter
- chaos_w  out  32  state w, Q8.24
- chaos_x  out  32  state x, Q8.24
- chaos_y  out  32  state y, Q8.24
- chaos_z  out  32  state z, Q8.24

Behaviour:
- Reset values (async reset): w = x = y = z = INIT_VAL, chaos_done = 0, chaos_temp = 0, FSM = IDLE, step_q = 0.
- Equations, with a = 10, c = 28, b ≈ 8/3, r = -1:
  - dx = 10(y-x) + w
  - dy = 28x - y - xz
  - dz = xy - b·z
  - dw = -yz - w
- Constant multiplies use shift-add only:
  - 10d = (d<<3) + (d<<1)
  - 28x = (x<<5) - (x<<2)
  - b·z = (z<<1) + (z>>>1) + (z>>>3) + (z>>>5), i.e. b = 2.65625
- Products: signed 32x32 → 64, result = bits [55:24], truncated, no rounding.
- Derivatives are computed at 36 bits. Update is s' = s + (ds >>> k), arithmetic shift.
- k = max(chaos_shift[4:0], MIN_SHIFT).
- The 36-bit sum saturates to 32'h7FFF_FFFF / 32'h8000_0000.
- FSM states and transitions:
  - IDLE → MUL_XZ when chaos_step = 1 and step_q = 0 (rising edge; step_q is chaos_step registered).
  - MUL_XZ → MUL_XY → MUL_YZ, one product latched per cycle.
  - MUL_YZ → UPDATE. UPDATE computes all four derivatives and new states from the state captured at step start.
  - UPDATE → DONE. On this transition w/x/y/z are written atomically, chaos_temp increments, and chaos_done is set.
  - DONE → IDLE when chaos_step = 0. chaos_done clears on that same edge.
- Latency: rising edge of chaos_step seen at cycle N → chaos_done = 1 and new state visible at cycle N+5.
- Outputs hold their values across MUL/UPDATE; only the DONE entry changes them.
- Handshake: a new step starts only after chaos_step has gone low (done cleared) and risen again. A step held high yields exactly one update.
- chaos_temp wraps from 8191 to 0.
- chaos_reset (synchronous, priority over step in any state, including mid-sequence):
  - Loads INIT_VAL into all states, clears chaos_temp and chaos_done, FSM → IDLE.
  - Any in-flight product is discarded.
  - If chaos_step is still high afterwards, no step starts until it falls and rises again (step_q still tracks).
- chaos_shift is sampled at UPDATE. Changes between steps take effect on the next step.

Decomposition:
- chaos_pkg holds:
  - Q-format constants (WIDTH, FRAC_BITS)
  - INIT_VAL
  - FSM state enum (IDLE, MUL_XZ, MUL_XY, MUL_YZ, UPDATE, DONE)
  - sat32 function (36 → 32 saturate)
- Sub-module chaos_fxp_mul: combinational signed Q8.24 32x32 multiply with [55:24] truncation. It is instantiated once and the operand mux is driven by the FSM.

Test Plan:
- Async reset, then release → w/x/y/z = 32'h0100_0000, done = 0, temp = 0, for all cycles until the first step.
- Reset values, shift = 8, single step pulse → at N+5: x = 32'h0101_0000, y = 32'h011A_0000, z = 32'h00FE_5800, w = 32'h00FE_0000, done = 1, temp = 1.
- Hold step high for 20 cycles after done → exactly one update, temp stays 1. Then step low → done = 0 next cycle, step high → temp = 2.
- Assert chaos_reset during MUL_XY (step still high) → next cycle states = INIT_VAL, temp = 0, done = 0. No update occurs until step falls and rises again.
- shift = 0 from init, one step → same as shift = 4: x = 32'h0110_0000, w = 32'h00E0_0000.
- 8192 completed steps with shift = 31 → temp reads 0. No saturation; states remain within ±128.
